// File: rtl/tow_pkg.sv
// Shared definitions for the push-button arbiter: state encoding, counter width,
// and the combinational helpers used to pick a winner and detect ties.
package tow_pkg;

    localparam int CNT_W = 8;
    localparam int MAX_CH = 16;

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_WINDOW = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [3:0] lowest_idx(input logic [MAX_CH-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic [4:0] popcount(input logic [MAX_CH-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/pb_sync_edge.sv
// One push-button channel: two-flop synchroniser, then a registered
// single-cycle pulse on each 0->1 transition of the synchronised level.
module pb_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_pb,
    output logic o_press
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_meta  <= i_pb;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_press <= r_sync & ~r_prev;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/push_arbiter.sv
// First-press arbiter: latches the first player to press, collects further
// presses during a short tie window, then holds the round result until clr.
module push_arbiter
    import tow_pkg::*;
#(
    parameter int N_PLAYERS  = 2,
    parameter int TIE_WINDOW = 4,
    parameter int IDX_W      = $clog2(N_PLAYERS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_PLAYERS-1:0] pb,
    input  logic                 clr,
    output logic                 push,
    output logic                 tie,
    output logic [IDX_W-1:0]     winner,
    output logic [N_PLAYERS-1:0] hits,
    output logic                 busy
);

    logic [N_PLAYERS-1:0] w_press;

    generate
        for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_ch
            pb_sync_edge u_sync (
                .clk     (clk),
                .rst     (rst),
                .i_pb    (pb[gi]),
                .o_press (w_press[gi])
            );
        end
    endgenerate

    state_t               r_state, w_state_next;
    logic [CNT_W-1:0]     r_cnt, w_cnt_next;
    logic [N_PLAYERS-1:0] r_hits, w_hits_next;
    logic [IDX_W-1:0]     r_winner, w_winner_next;
    logic                 r_push, r_tie, r_busy;
    logic                 w_push_next, w_tie_next, w_busy_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_ARMED;
            r_cnt    <= '0;
            r_hits   <= '0;
            r_winner <= '0;
            r_push   <= 1'b0;
            r_tie    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_hits   <= w_hits_next;
            r_winner <= w_winner_next;
            r_push   <= w_push_next;
            r_tie    <= w_tie_next;
            r_busy   <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_hits_next   = r_hits;
        w_winner_next = r_winner;
        if (clr) begin
            w_state_next  = ST_ARMED;
            w_cnt_next    = '0;
            w_hits_next   = '0;
            w_winner_next = '0;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (|w_press) begin
                        w_hits_next   = w_press;
                        w_winner_next = IDX_W'(lowest_idx(MAX_CH'(w_press)));
                        if (TIE_WINDOW > 0) begin
                            w_state_next = ST_WINDOW;
                            w_cnt_next   = CNT_W'(TIE_WINDOW - 1);
                        end else begin
                            w_state_next = ST_RESULT;
                        end
                    end
                end
                ST_WINDOW: begin
                    w_hits_next = r_hits | w_press;
                    if (r_cnt == '0) begin
                        w_state_next = ST_RESULT;
                    end else begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end
                end
                ST_RESULT: ;
                default: w_state_next = ST_ARMED;
            endcase
        end
    end

    // Flag values are derived from the next state so the flops themselves are the outputs.
    always_comb begin
        w_push_next = (w_state_next == ST_RESULT);
        w_busy_next = (w_state_next == ST_WINDOW);
        w_tie_next  = w_push_next && (popcount(MAX_CH'(w_hits_next)) >= 5'd2);
    end

    assign push   = r_push;
    assign tie    = r_tie;
    assign busy   = r_busy;
    assign winner = r_winner;
    assign hits   = r_hits;

endmodule

// File: tb/tb_push_arbiter.sv
// Bench for push_arbiter: DUT A (2 players, window 4) and DUT B (4 players, no window),
// expected round results queued at stimulus time and compared when push rises.
module tb_push_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] pb_a;
    logic       clr_a;
    logic       push_a, tie_a, busy_a;
    logic [0:0] winner_a;
    logic [1:0] hits_a;

    logic [3:0] pb_b;
    logic       clr_b;
    logic       push_b, tie_b, busy_b;
    logic [1:0] winner_b;
    logic [3:0] hits_b;

    push_arbiter #(.N_PLAYERS(2), .TIE_WINDOW(4)) u_dut_a (
        .clk(clk), .rst(rst), .pb(pb_a), .clr(clr_a),
        .push(push_a), .tie(tie_a), .winner(winner_a), .hits(hits_a), .busy(busy_a)
    );

    push_arbiter #(.N_PLAYERS(4), .TIE_WINDOW(0)) u_dut_b (
        .clk(clk), .rst(rst), .pb(pb_b), .clr(clr_b),
        .push(push_b), .tie(tie_b), .winner(winner_b), .hits(hits_b), .busy(busy_b)
    );

    typedef struct packed {
        logic [3:0]  w;
        logic [15:0] h;
        logic        t;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    logic pa_prev = 1'b0;
    logic pbp_prev = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Scoreboard monitors: one comparison set per rising push.
    always @(negedge clk) begin
        if (push_a && !pa_prev) begin
            if (qa.size() == 0) begin
                check("a_unexpected_push", 32'(push_a), 32'(0));
            end else begin
                ea = qa.pop_front();
                check("a_winner", 32'(winner_a), 32'(ea.w));
                check("a_hits", 32'(hits_a), 32'(ea.h));
                check("a_tie", 32'(tie_a), 32'(ea.t));
                check("a_excl", 32'(busy_a), 32'(0));
            end
        end
        pa_prev = push_a;
    end

    always @(negedge clk) begin
        if (push_b && !pbp_prev) begin
            if (qb.size() == 0) begin
                check("b_unexpected_push", 32'(push_b), 32'(0));
            end else begin
                eb = qb.pop_front();
                check("b_winner", 32'(winner_b), 32'(eb.w));
                check("b_hits", 32'(hits_b), 32'(eb.h));
                check("b_tie", 32'(tie_b), 32'(eb.t));
            end
        end
        pbp_prev = push_b;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_push_a(input int budget);
        int k;
        k = 0;
        while (!push_a && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("a_push_arrived", 32'(push_a), 32'(1));
    endtask

    task automatic wait_push_b(input int budget);
        int k;
        k = 0;
        while (!push_b && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("b_push_arrived", 32'(push_b), 32'(1));
    endtask

    task automatic rearm_a();
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        check("a_rearm_push", 32'(push_a), 32'(0));
        check("a_rearm_tie", 32'(tie_a), 32'(0));
        check("a_rearm_hits", 32'(hits_a), 32'(0));
        check("a_rearm_winner", 32'(winner_a), 32'(0));
    endtask

    task automatic rearm_b();
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        check("b_rearm_push", 32'(push_b), 32'(0));
        check("b_rearm_hits", 32'(hits_b), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_busy, first_push;
        bit busy_seen;

        rst   = 1'b1;
        pb_a  = '0;
        clr_a = 1'b0;
        pb_b  = '0;
        clr_b = 1'b0;
        tick(3);
        check("rst_push_a", 32'(push_a), 32'(0));
        check("rst_tie_a", 32'(tie_a), 32'(0));
        check("rst_busy_a", 32'(busy_a), 32'(0));
        check("rst_hits_a", 32'(hits_a), 32'(0));
        check("rst_winner_a", 32'(winner_a), 32'(0));
        check("rst_push_b", 32'(push_b), 32'(0));
        rst = 1'b0;
        tick(2);

        // Single press: busy 3 cycles after sampling, push after a 4-cycle window.
        pb_a = 2'b01;
        qa.push_back('{w: 4'd0, h: 16'h1, t: 1'b0});
        first_busy = 0;
        first_push = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy_a && first_busy == 0) first_busy = k;
            if (push_a && first_push == 0) first_push = k;
        end
        check("t1_busy_latency", 32'(first_busy), 32'(4));
        check("t1_push_latency", 32'(first_push), 32'(8));
        pb_a = 2'b00;
        rearm_a();
        tick(3);

        // Second player two cycles late: still inside the window -> tie.
        pb_a = 2'b10;
        qa.push_back('{w: 4'd1, h: 16'h3, t: 1'b1});
        tick(2);
        pb_a = 2'b11;
        wait_push_a(15);
        tick(1);
        pb_a = 2'b00;
        rearm_a();
        tick(3);

        // Second player six cycles late: arrives after the window closed.
        pb_a = 2'b10;
        qa.push_back('{w: 4'd1, h: 16'h2, t: 1'b0});
        tick(6);
        pb_a = 2'b11;
        tick(8);
        check("t3_hits_frozen", 32'(hits_a), 32'(2'b10));
        check("t3_tie_frozen", 32'(tie_a), 32'(0));

        // clr while pb[0] held: no press until it is released and pressed again.
        pb_a = 2'b01;
        rearm_a();
        tick(10);
        check("t4_held_no_push", 32'(push_a), 32'(0));
        check("t4_held_no_busy", 32'(busy_a), 32'(0));
        pb_a = 2'b00;
        tick(3);
        pb_a = 2'b01;
        qa.push_back('{w: 4'd0, h: 16'h1, t: 1'b0});
        wait_push_a(15);
        tick(1);

        // clr lands in the same cycle as a fresh press pulse in RESULT.
        pb_a = 2'b11;
        tick(3);
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        tick(10);
        check("t5_clr_prio_push", 32'(push_a), 32'(0));
        check("t5_clr_prio_busy", 32'(busy_a), 32'(0));
        check("t5_clr_prio_hits", 32'(hits_a), 32'(0));
        pb_a = 2'b00;
        tick(3);

        // Asynchronous reset in the middle of the window discards the round.
        pb_a = 2'b01;
        qa.push_back('{w: 4'd0, h: 16'h1, t: 1'b0});
        tick(5);
        check("t6_busy_before_rst", 32'(busy_a), 32'(1));
        #2 rst = 1'b1;
        #1;
        check("t6_rst_busy", 32'(busy_a), 32'(0));
        check("t6_rst_hits", 32'(hits_a), 32'(0));
        check("t6_rst_push", 32'(push_a), 32'(0));
        qa.delete();
        pb_a = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        tick(15);
        check("t6_no_push_after", 32'(push_a), 32'(0));
        check("t6_no_busy_after", 32'(busy_a), 32'(0));

        // Button already high when reset releases counts as a press.
        rst = 1'b1;
        pb_a = 2'b10;
        tick(2);
        qa.push_back('{w: 4'd1, h: 16'h2, t: 1'b0});
        rst = 1'b0;
        wait_push_a(15);
        pb_a = 2'b00;
        rearm_a();
        tick(3);

        // DUT B, no window: simultaneous presses resolve straight to RESULT.
        pb_b = 4'b1010;
        qb.push_back('{w: 4'd1, h: 16'ha, t: 1'b1});
        first_push = 0;
        busy_seen = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (busy_b) busy_seen = 1'b1;
            if (push_b && first_push == 0) first_push = k;
        end
        check("b1_push_latency", 32'(first_push), 32'(4));
        check("b1_busy_never", 32'(busy_seen), 32'(0));
        pb_b = 4'b0000;
        rearm_b();
        tick(3);

        pb_b = 4'b1000;
        qb.push_back('{w: 4'd3, h: 16'h8, t: 1'b0});
        wait_push_b(10);
        pb_b = 4'b0000;
        rearm_b();
        tick(3);

        pb_b = 4'b0110;
        qb.push_back('{w: 4'd1, h: 16'h6, t: 1'b1});
        wait_push_b(10);
        pb_b = 4'b0000;
        rearm_b();
        tick(2);

        check("a_sb_drain", 32'(qa.size()), 32'(0));
        check("b_sb_drain", 32'(qb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
